// File: rtl/flb_sdm_pkg.sv
// Shared types and helpers for the MASH 1-1-1 sigma-delta modulator.
//   sdm_order_e : run-time order select (index 0 = 1st order)
//   sdm_ofs     : offset-binary mid-code for a given maximum order
//   thrm_enc    : LSB-first thermometer encoding of a code
//   OUT_W/THRM_W: output widths for the default three-stage build
package flb_sdm_pkg;

    typedef enum logic [1:0] {
        SDM_ORD1 = 2'd0,
        SDM_ORD2 = 2'd1,
        SDM_ORD3 = 2'd2
    } sdm_order_e;

    localparam int OUT_W    = 3;
    localparam int THRM_W   = (1 << OUT_W) - 1;
    localparam int THRM_MAX = 64;

    function automatic int sdm_ofs(input int max_order);
        return (1 << (max_order - 1)) - 1;
    endfunction

    // Returns 'code' ones starting at bit 0, limited to 'width' bits.
    function automatic logic [THRM_MAX-1:0] thrm_enc(input int code, input int width);
        logic [THRM_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < THRM_MAX; i++) begin
            if (i < code && i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sdm_acc_stage.sv
// One MASH accumulator stage: modulo-2^DATA_W accumulator with carry out
// and two cycles of carry history.
// Ports:
//   nsh_clk, nsh_rst : clock, async active-high reset
//   clear            : synchronous clear of accumulator and history
//   freeze           : hold accumulator and history (clear wins)
//   addend, cin      : value and carry-in added this cycle
//   sum_nxt, carry   : combinational next sum and carry (feed next stage)
//   c_z1, c_z2       : carry delayed by one and two updates
module sdm_acc_stage
    import flb_sdm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              nsh_clk,
    input  logic              nsh_rst,
    input  logic              clear,
    input  logic              freeze,
    input  logic [DATA_W-1:0] addend,
    input  logic              cin,
    output logic [DATA_W-1:0] sum_nxt,
    output logic              carry,
    output logic              c_z1,
    output logic              c_z2
);

    logic [DATA_W-1:0] s_q;

    assign {carry, sum_nxt} = {1'b0, s_q} + {1'b0, addend} + (DATA_W+1)'(cin);

    always_ff @(posedge nsh_clk or posedge nsh_rst) begin
        if (nsh_rst) begin
            s_q  <= '0;
            c_z1 <= 1'b0;
            c_z2 <= 1'b0;
        end else if (clear) begin
            s_q  <= '0;
            c_z1 <= 1'b0;
            c_z2 <= 1'b0;
        end else if (!freeze) begin
            s_q  <= sum_nxt;
            c_z1 <= carry;
            c_z2 <= c_z1;
        end
    end

endmodule

// File: rtl/sdm_mash_param.sv
// Parametrised MASH 1-1-1 sigma-delta modulator for the fractional divider.
// Ports:
//   nsh_clk, nsh_rst : clock, async active-high reset
//   os_data          : unsigned fraction input
//   sdm_on           : 1 = modulate, 0 = hold cleared with mid-code output
//   sdm_order        : 0/1/2 = 1st/2nd/3rd order, larger values clamp to max
//   sdm_dither_en    : LFSR bit as carry-in of the first accumulator
//   sdm_man_on/val   : manual override of os_bin (accumulators frozen)
//   sdm_thrm_en      : enable thermometer output
//   os_bin           : offset-binary output code
//   os_thrm          : LSB-first thermometer copy of os_bin
module sdm_mash_param
    import flb_sdm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_ORDER = 3,
    parameter int DITHER_EN = 1
) (
    input  logic                        nsh_clk,
    input  logic                        nsh_rst,
    input  logic [DATA_W-1:0]           os_data,
    input  logic                        sdm_on,
    input  logic [1:0]                  sdm_order,
    input  logic                        sdm_dither_en,
    input  logic                        sdm_man_on,
    input  logic [MAX_ORDER-1:0]        sdm_man_val,
    input  logic                        sdm_thrm_en,
    output logic [MAX_ORDER-1:0]        os_bin,
    output logic [(1<<MAX_ORDER)-2:0]   os_thrm
);

    localparam int         BIN_W   = MAX_ORDER;
    localparam int         THRM_N  = (1 << MAX_ORDER) - 1;
    localparam int         YW      = MAX_ORDER + 2;
    localparam int         OFS     = sdm_ofs(MAX_ORDER);
    localparam logic [1:0] ORD_MAX = 2'(MAX_ORDER - 1);

    logic       dith_bit;
    sdm_order_e order_q;
    sdm_order_e ord_eff;
    logic       clr;

    // LFSR x^15 + x^14 + 1, runs whenever the modulator is on
    if (DITHER_EN != 0) begin : g_lfsr
        logic [14:0] lfsr_q;
        always_ff @(posedge nsh_clk or posedge nsh_rst) begin
            if (nsh_rst)     lfsr_q <= 15'h0001;
            else if (sdm_on) lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
        assign dith_bit = lfsr_q[0] & sdm_dither_en;
    end else begin : g_no_lfsr
        assign dith_bit = 1'b0;
    end

    assign ord_eff = (sdm_order > ORD_MAX) ? sdm_order_e'(ORD_MAX) : sdm_order_e'(sdm_order);
    // An order change costs one clearing edge so the new loop starts from zero
    assign clr     = !sdm_on || (ord_eff != order_q);

    // Stages chain on next-sums; positions above MAX_ORDER read as zero
    logic [DATA_W-1:0] chain [0:MAX_ORDER];
    logic [2:0]        c, cz1, cz2;
    logic [DATA_W-1:0] sum_unused;
    logic [2:0]        hist_unused;

    assign chain[0]   = os_data;
    assign sum_unused = chain[MAX_ORDER];

    for (genvar i = 0; i < 3; i++) begin : g_stage
        if (i < MAX_ORDER) begin : g_on
            sdm_acc_stage #(.DATA_W(DATA_W)) u_stage (
                .nsh_clk (nsh_clk),
                .nsh_rst (nsh_rst),
                .clear   (clr),
                .freeze  (sdm_man_on),
                .addend  (chain[i]),
                .cin     ((i == 0) ? dith_bit : 1'b0),
                .sum_nxt (chain[i+1]),
                .carry   (c[i]),
                .c_z1    (cz1[i]),
                .c_z2    (cz2[i])
            );
        end else begin : g_off
            assign c[i]   = 1'b0;
            assign cz1[i] = 1'b0;
            assign cz2[i] = 1'b0;
        end
    end

    // Histories that the noise-cancel sum does not need
    assign hist_unused = {cz1[0], cz2[1], cz2[0]};

    logic signed [YW-1:0] y;
    logic [BIN_W-1:0]     bin_d;
    logic [THRM_N-1:0]    thrm_d;

    always_comb begin
        y = YW'(c[0]);
        if (order_q >= SDM_ORD2) y = y + YW'(c[1]) - YW'(cz1[1]);
        if (order_q >= SDM_ORD3) y = y + YW'(c[2]) - YW'({cz1[2], 1'b0}) + YW'(cz2[2]);

        if (clr)             bin_d = BIN_W'(OFS);
        else if (sdm_man_on) bin_d = sdm_man_val;
        else                 bin_d = BIN_W'(y + YW'(OFS));

        thrm_d = sdm_thrm_en ? THRM_N'(thrm_enc(int'(bin_d), THRM_N)) : '0;
    end

    always_ff @(posedge nsh_clk or posedge nsh_rst) begin
        if (nsh_rst) begin
            order_q <= SDM_ORD1;
            os_bin  <= BIN_W'(OFS);
            os_thrm <= '0;
        end else begin
            order_q <= ord_eff;
            os_bin  <= bin_d;
            os_thrm <= thrm_d;
        end
    end

endmodule

// File: tb/tb_sdm_mash_param.sv
// Directed bench for sdm_mash_param (DATA_W=8, MAX_ORDER=3, OFS=3).
module tb_sdm_mash_param;

    logic       nsh_clk = 1'b0;
    logic       nsh_rst;
    logic [7:0] os_data;
    logic       sdm_on;
    logic [1:0] sdm_order;
    logic       sdm_dither_en;
    logic       sdm_man_on;
    logic [2:0] sdm_man_val;
    logic       sdm_thrm_en;
    logic [2:0] os_bin;
    logic [6:0] os_thrm;

    int n_chk = 0;
    int n_err = 0;

    always #5 nsh_clk = ~nsh_clk;

    sdm_mash_param #(.DATA_W(8), .MAX_ORDER(3), .DITHER_EN(1)) dut (
        .nsh_clk       (nsh_clk),
        .nsh_rst       (nsh_rst),
        .os_data       (os_data),
        .sdm_on        (sdm_on),
        .sdm_order     (sdm_order),
        .sdm_dither_en (sdm_dither_en),
        .sdm_man_on    (sdm_man_on),
        .sdm_man_val   (sdm_man_val),
        .sdm_thrm_en   (sdm_thrm_en),
        .os_bin        (os_bin),
        .os_thrm       (os_thrm)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge nsh_clk);
        #1;
    endtask

    initial begin
        int sum;
        int viol;
        int nonconst;
        int exp_o1 [4];
        int exp_o3 [8];
        int exp_o1b [8];
        exp_o1  = '{3, 4, 3, 4};
        exp_o3  = '{3, 5, 2, 4, 3, 5, 2, 4};
        exp_o1b = '{3, 4, 4, 4, 3, 4, 4, 4};

        nsh_rst = 1'b1; sdm_on = 1'b0; os_data = 8'h00; sdm_order = 2'd0;
        sdm_dither_en = 1'b0; sdm_man_on = 1'b0; sdm_man_val = 3'd0; sdm_thrm_en = 1'b1;
        #3;
        chk("rst_bin", os_bin, 3);
        chk("rst_thrm", os_thrm, 0);

        // 1st order, x = 1/2 -> alternating 3,4
        @(posedge nsh_clk); #1;
        nsh_rst = 1'b0; sdm_on = 1'b1; os_data = 8'h80;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("o1_half_bin", os_bin, exp_o1[k]);
        end
        chk("o1_thrm4", os_thrm, 7'b0001111);

        // asynchronous reset between edges
        #2 nsh_rst = 1'b1;
        #1;
        chk("arst_bin", os_bin, 3);
        chk("arst_thrm", os_thrm, 0);
        step();
        nsh_rst = 1'b0;

        // order value 3 clamps to 3rd order; one clearing edge, then 3,5,2,4
        sdm_order = 2'd3;
        step();
        chk("o3_clr_bin", os_bin, 3);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("o3_seq_bin", os_bin, exp_o3[k]);
            if (k == 1) chk("o3_thrm5", os_thrm, 7'b0011111);
            if (k == 2) chk("o3_thrm2", os_thrm, 7'b0000011);
        end

        // manual override freezes the loop
        step(); chk("pre_man_a", os_bin, 3);
        step(); chk("pre_man_b", os_bin, 5);
        sdm_man_on = 1'b1; sdm_man_val = 3'd6;
        step(); chk("man_bin", os_bin, 6); chk("man_thrm", os_thrm, 7'b0111111);
        step(); chk("man_hold", os_bin, 6);
        sdm_man_on = 1'b0;
        step(); chk("man_rel_a", os_bin, 2);
        step(); chk("man_rel_b", os_bin, 4);
        sdm_thrm_en = 1'b0;
        step(); chk("thrm_off_bin", os_bin, 3); chk("thrm_off", os_thrm, 0);
        step(); chk("thrm_off_bin2", os_bin, 5); chk("thrm_off2", os_thrm, 0);
        sdm_thrm_en = 1'b1;
        step(); chk("thrm_on_bin", os_bin, 2); chk("thrm_on", os_thrm, 7'b0000011);

        // 2nd order, x = 0x40 over 256 cycles: sum = 256*3 + 64
        sdm_order = 2'd1; os_data = 8'h40;
        step(); chk("o2_clr_bin", os_bin, 3);
        sum = 0; viol = 0;
        repeat (256) begin
            step();
            sum += int'(os_bin);
            if (os_bin < 3'd2 || os_bin > 3'd5) viol++;
        end
        chk("o2_sum", sum, 832);
        chk("o2_range", viol, 0);

        // order change 2nd -> 1st mid-run
        os_data = 8'hC0; viol = 0;
        repeat (5) begin
            step();
            if (os_bin < 3'd2 || os_bin > 3'd5) viol++;
        end
        chk("o2_c0_range", viol, 0);
        sdm_order = 2'd0;
        step(); chk("o21_clr_bin", os_bin, 3);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("o1_c0_bin", os_bin, exp_o1b[k]);
        end

        // 3rd order, x = 0xFF over 1024 cycles
        sdm_order = 2'd2; os_data = 8'hFF;
        step(); chk("o3ff_clr_bin", os_bin, 3);
        sum = 0;
        repeat (1024) begin
            step();
            sum += int'(os_bin);
        end
        chk("o3ff_mean_ok", (sum >= 4087 && sum <= 4097) ? 1 : 0, 1);

        // off clears, then x = 0 without dither stays at mid-code
        sdm_on = 1'b0; os_data = 8'h00;
        step(); chk("off_bin", os_bin, 3);
        sdm_on = 1'b1; viol = 0;
        repeat (64) begin
            step();
            if (os_bin != 3'd3) viol++;
        end
        chk("zero_const", viol, 0);

        // dither on with x = 0
        sdm_dither_en = 1'b1; sum = 0; nonconst = 0;
        repeat (4096) begin
            step();
            sum += int'(os_bin);
            if (os_bin != 3'd3) nonconst++;
        end
        chk("dith_varies", (nonconst > 0) ? 1 : 0, 1);
        chk("dith_mean_ok", (sum >= 12248 && sum <= 12328) ? 1 : 0, 1);
        sdm_on = 1'b0;
        step(); chk("dith_off_bin", os_bin, 3); chk("dith_off_thrm", os_thrm, 7'b0000111);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
